// File: rtl/alu_console_if.sv
// Board I/O bundle for alu_console: switch/button pins in, LED/status out.
interface alu_console_if #(
   parameter int NB_DATA = 8,
   parameter int NB_SW   = 8,
   parameter int NB_BTN  = 4
);
   logic [NB_SW-1:0]   i_sw;
   logic [NB_BTN-1:0]  i_btn;
   logic [NB_DATA-1:0] o_led;
   logic [3:0]         o_status;
   logic               o_valid;
   logic [2:0]         o_loaded;

   modport master (output i_sw, i_btn, input o_led, o_status, o_valid, o_loaded);
   modport slave  (input i_sw, i_btn, output o_led, o_status, o_valid, o_loaded);
endinterface

// File: rtl/alu_console.sv
// Debounced button front-end plus operand/opcode loader and registered ALU
// execution with {error, overflow, carry, zero} flags.
module alu_console_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          s1, s2, acc, armed;
   logic [CW-1:0] cnt;
   logic          chg;

   // Until a low level has been accepted after reset, the button is not armed,
   // so a button held through reset release never fires.
   assign chg = armed ? (s2 != acc) : ~s2;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         acc     <= 1'b0;
         armed   <= 1'b0;
         cnt     <= '0;
         o_pulse <= 1'b0;
      end else begin
         s1      <= i_btn;
         s2      <= s1;
         o_pulse <= 1'b0;
         if (!chg) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            if (armed) begin
               acc     <= s2;
               o_pulse <= s2;
            end else begin
               armed <= 1'b1;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module alu_console #(
   parameter int NB_DATA         = 8,
   parameter int NB_OP           = 6,
   parameter int NB_SW           = 8,
   parameter int NB_BTN          = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input logic         i_clk,
   input logic         i_reset,
   alu_console_if.slave bus
);
   localparam int MSB = NB_DATA - 1;
   localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
   localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
   localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
   localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
   localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
   localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
   localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
   localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

   typedef enum logic [1:0] {S_LOAD, S_READY, S_DONE} state_t;

   typedef struct packed {
      logic [NB_DATA-1:0] res;
      logic               err;
      logic               ovf;
      logic               carry;
      logic               zero;
   } res_t;

   function automatic res_t alu_exec(input logic [NB_DATA-1:0] a, b,
                                     input logic [NB_OP-1:0]   op);
      logic [NB_DATA:0] ext;
      res_t r;
      r   = '0;
      ext = '0;
      case (op)
         OP_ADD: begin
            ext     = {1'b0, a} + {1'b0, b};
            r.res   = ext[MSB:0];
            r.carry = ext[NB_DATA];
            r.ovf   = (a[MSB] == b[MSB]) && (r.res[MSB] != a[MSB]);
         end
         OP_SUB: begin
            // The extra bit of the widened difference is the unsigned borrow.
            ext     = {1'b0, a} - {1'b0, b};
            r.res   = ext[MSB:0];
            r.carry = ext[NB_DATA];
            r.ovf   = (a[MSB] != b[MSB]) && (r.res[MSB] != a[MSB]);
         end
         OP_AND: r.res = a & b;
         OP_OR:  r.res = a | b;
         OP_XOR: r.res = a ^ b;
         OP_NOR: r.res = ~(a | b);
         OP_SRL: r.res = (32'(b) >= NB_DATA) ? '0 : (a >> b);
         OP_SRA: r.res = (32'(b) >= NB_DATA) ? {NB_DATA{a[MSB]}}
                                              : NB_DATA'($signed(a) >>> b);
         default: r.err = 1'b1;
      endcase
      r.zero = ~r.err & (r.res == '0);
      return r;
   endfunction

   logic [NB_SW-1:0]   sw_m, sw_s;
   logic [NB_BTN-1:0]  pulse;
   logic [2:0]         ld_bit, loaded_q;
   logic               exec;
   state_t             state;
   logic [NB_DATA-1:0] a_q, b_q, led_q;
   logic [NB_OP-1:0]   op_q;
   logic [3:0]         status_q;
   logic               valid_q;
   res_t               res;

   for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
      alu_console_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_btn   (bus.i_btn[g]),
         .o_pulse (pulse[g])
      );
   end

   // Priority A > B > op > exec; lower pulses in the same cycle are dropped.
   always_comb begin
      ld_bit = 3'b000;
      if      (pulse[0]) ld_bit = 3'b001;
      else if (pulse[1]) ld_bit = 3'b010;
      else if (pulse[2]) ld_bit = 3'b100;
      exec = pulse[3] & ~|pulse[2:0];
   end

   assign res = alu_exec(a_q, b_q, op_q);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sw_m     <= '0;
         sw_s     <= '0;
         state    <= S_LOAD;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         led_q    <= '0;
         status_q <= '0;
         valid_q  <= 1'b0;
         loaded_q <= '0;
      end else begin
         sw_m <= bus.i_sw;
         sw_s <= sw_m;
         if (|ld_bit) begin
            if (ld_bit[0]) a_q  <= sw_s[NB_DATA-1:0];
            if (ld_bit[1]) b_q  <= sw_s[NB_DATA-1:0];
            if (ld_bit[2]) op_q <= sw_s[NB_OP-1:0];
            loaded_q <= loaded_q | ld_bit;
            valid_q  <= 1'b0;
            state    <= (&(loaded_q | ld_bit)) ? S_READY : S_LOAD;
         end else if (exec) begin
            if (state == S_LOAD) begin
               status_q <= 4'b1000;
               valid_q  <= 1'b0;
            end else begin
               led_q    <= res.res;
               status_q <= {res.err, res.ovf, res.carry, res.zero};
               valid_q  <= 1'b1;
               state    <= S_DONE;
            end
         end
      end
   end

   assign bus.o_led    = led_q;
   assign bus.o_status = status_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_loaded = loaded_q;
endmodule
